// File: rtl/tone_pkg.sv
// Shared definitions for the multi-voice tone mixer: register selects, voice modes
// and the 15-bit noise LFSR (x^15 + x^14 + 1).
package tone_pkg;

    typedef enum logic {
        REG_PERIOD = 1'b0,
        REG_CTRL   = 1'b1
    } reg_sel_e;

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_NOISE  = 1'b1
    } mode_e;

    localparam int              LFSR_W      = 15;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h7FFF;
    localparam int              LFSR_TAP_HI = 14;   // x^15 term
    localparam int              LFSR_TAP_LO = 13;   // x^14 term

    // Fibonacci step: the feedback bit enters at bit 0, which is the noise output.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/tone_voice.sv
// One oscillator voice: period/volume/mode registers, half-period down-counter,
// square-wave toggle bit and noise LFSR.
module tone_voice
    import tone_pkg::*;
#(
    parameter int PERIOD_W = 12,
    parameter int VOL_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick_i,
    input  logic                per_we_i,
    input  logic                ctl_we_i,
    input  logic [PERIOD_W-1:0] wr_data_i,
    output logic                bit_o,
    output logic [VOL_W-1:0]    vol_o
);

    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q,    cnt_d;
    logic [VOL_W-1:0]    vol_q,    vol_d;
    mode_e               mode_q,   mode_d;
    logic                sq_q,     sq_d;
    logic [LFSR_W-1:0]   lfsr_q,   lfsr_d;

    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        vol_d    = vol_q;
        mode_d   = mode_q;
        sq_d     = sq_q;
        lfsr_d   = lfsr_q;

        // The tick sees the old register values; writes below override afterwards.
        if (tick_i && (period_q != '0)) begin
            if (cnt_q == '0) begin
                cnt_d = period_q;
                if (mode_q == MODE_NOISE) begin
                    lfsr_d = lfsr_step(lfsr_q);
                end else begin
                    sq_d = ~sq_q;
                end
            end else begin
                cnt_d = cnt_q - PERIOD_W'(1);
            end
        end

        // A non-zero period only lands in the register; the counter picks it up at the next reload.
        if (per_we_i) begin
            period_d = wr_data_i;
            if (wr_data_i == '0) begin
                cnt_d = '0;
                sq_d  = 1'b0;
            end
        end

        if (ctl_we_i) begin
            vol_d  = wr_data_i[VOL_W-1:0];
            mode_d = mode_e'(wr_data_i[VOL_W]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0;
            cnt_q    <= '0;
            vol_q    <= '0;
            mode_q   <= MODE_SQUARE;
            sq_q     <= 1'b0;
            lfsr_q   <= LFSR_SEED;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
            vol_q    <= vol_d;
            mode_q   <= mode_d;
            sq_q     <= sq_d;
            lfsr_q   <= lfsr_d;
        end
    end

    assign bit_o = (mode_q == MODE_NOISE) ? lfsr_q[0] : sq_q;
    assign vol_o = vol_q;

endmodule

// File: rtl/tone_mixer_synth.sv
// Multi-voice tone mixer: tick prescaler, write decode, per-voice oscillators,
// registered volume mix and a first-order sigma-delta modulator for the audio pad.
module tone_mixer_synth
    import tone_pkg::*;
#(
    parameter int VOICES   = 4,
    parameter int PERIOD_W = 12,
    parameter int VOL_W    = 4,
    parameter int PRESCALE = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [$clog2(VOICES):0]       wr_addr,
    input  logic [PERIOD_W-1:0]           wr_data,
    output logic                          tick_o,
    output logic [VOICES-1:0]             voice_o,
    output logic [VOL_W+$clog2(VOICES):0] mix_o,
    output logic                          pdm_o
);

    localparam int MIX_W  = VOL_W + $clog2(VOICES) + 1;
    localparam int PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int VIDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

    logic [PS_W-1:0] presc_q, presc_d;
    logic            tick_q,  tick_d;

    // Tick is registered so that it reads 0 during reset even when PRESCALE is 1.
    always_comb begin
        presc_d = (presc_q == PS_W'(PRESCALE - 1)) ? '0 : presc_q + PS_W'(1);
        tick_d  = (presc_d == PS_W'(PRESCALE - 1));
    end

    logic [VIDX_W-1:0] wr_voice;
    reg_sel_e          wr_sel;

    generate
        if (VOICES > 1) begin : g_vidx
            assign wr_voice = wr_addr[$clog2(VOICES):1];
        end else begin : g_vidx_one
            assign wr_voice = '0;
        end
    endgenerate

    assign wr_sel = reg_sel_e'(wr_addr[0]);

    logic [VOICES-1:0] per_we;
    logic [VOICES-1:0] ctl_we;
    logic [VOL_W-1:0]  vol [VOICES];

    generate
        for (genvar gi = 0; gi < VOICES; gi++) begin : g_voice
            assign per_we[gi] = wr_en && (wr_voice == VIDX_W'(gi)) && (wr_sel == REG_PERIOD);
            assign ctl_we[gi] = wr_en && (wr_voice == VIDX_W'(gi)) && (wr_sel == REG_CTRL);

            tone_voice #(
                .PERIOD_W (PERIOD_W),
                .VOL_W    (VOL_W)
            ) u_voice (
                .clk       (clk),
                .rst_n     (rst_n),
                .tick_i    (tick_q),
                .per_we_i  (per_we[gi]),
                .ctl_we_i  (ctl_we[gi]),
                .wr_data_i (wr_data),
                .bit_o     (voice_o[gi]),
                .vol_o     (vol[gi])
            );
        end
    endgenerate

    logic [MIX_W-1:0] mix_q, mix_d;
    logic [MIX_W-1:0] acc_q;
    logic             pdm_q;
    logic [MIX_W:0]   sd_sum;

    // The mix word has one spare MSB, so the sum of all voices can never wrap.
    always_comb begin
        mix_d = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (voice_o[i]) begin
                mix_d = mix_d + MIX_W'(vol[i]);
            end
        end
    end

    assign sd_sum = {1'b0, acc_q} + {1'b0, mix_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            mix_q   <= '0;
            acc_q   <= '0;
            pdm_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            mix_q   <= mix_d;
            acc_q   <= sd_sum[MIX_W-1:0];
            pdm_q   <= sd_sum[MIX_W];
        end
    end

    assign tick_o = tick_q;
    assign mix_o  = mix_q;
    assign pdm_o  = pdm_q;

endmodule

// File: tb/tb_tone_mixer_synth.sv
// Self-checking bench for tone_mixer_synth: directed scenarios plus random register
// writes, compared every cycle against a behavioural model of the voices and mixer.
module tb_tone_mixer_synth;

    localparam int VOICES   = 4;
    localparam int PERIOD_W = 12;
    localparam int VOL_W    = 4;
    localparam int PRESCALE = 1;
    localparam int MIX_W    = VOL_W + $clog2(VOICES) + 1;
    localparam int AW       = $clog2(VOICES) + 1;
    localparam int LFSR_LEN = 32767;
    localparam int SEQ_N    = LFSR_LEN + 14 + 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                wr_en = 1'b0;
    logic [AW-1:0]       wr_addr = '0;
    logic [PERIOD_W-1:0] wr_data = '0;
    logic                tick_o;
    logic [VOICES-1:0]   voice_o;
    logic [MIX_W-1:0]    mix_o;
    logic                pdm_o;

    tone_mixer_synth #(
        .VOICES   (VOICES),
        .PERIOD_W (PERIOD_W),
        .VOL_W    (VOL_W),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .tick_o  (tick_o),
        .voice_o (voice_o),
        .mix_o   (mix_o),
        .pdm_o   (pdm_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Noise bit stream: seq[14+n] is the voice output after n LFSR steps from the all-ones seed,
    // following the recurrence s[m] = s[m-15] xor s[m-14].
    bit seq [SEQ_N];

    // Behavioural model, updated on the same edges as the DUT.
    int m_per  [VOICES];
    int m_vol  [VOICES];
    int m_mode [VOICES];
    int m_cnt  [VOICES];
    int m_sq   [VOICES];
    int m_nidx [VOICES];
    int m_mix;
    int m_acc;
    int m_pdm;
    int m_tick;

    function automatic int m_vout(input int v);
        return (m_mode[v] != 0) ? int'(seq[14 + m_nidx[v]]) : m_sq[v];
    endfunction

    function automatic int m_voice_word();
        int w = 0;
        for (int v = 0; v < VOICES; v++) w += m_vout(v) << v;
        return w;
    endfunction

    function automatic int m_mix_next();
        int s = 0;
        for (int v = 0; v < VOICES; v++) if (m_vout(v) != 0) s += m_vol[v];
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < VOICES; v++) begin
                m_per[v]  <= 0;
                m_vol[v]  <= 0;
                m_mode[v] <= 0;
                m_cnt[v]  <= 0;
                m_sq[v]   <= 0;
                m_nidx[v] <= 0;
            end
            m_mix  <= 0;
            m_acc  <= 0;
            m_pdm  <= 0;
            m_tick <= 0;
        end else begin
            m_tick <= 1;   // PRESCALE of 1: every cycle is a tick once out of reset
            for (int v = 0; v < VOICES; v++) begin
                if (m_tick != 0 && m_per[v] != 0) begin
                    if (m_cnt[v] == 0) begin
                        m_cnt[v] <= m_per[v];
                        if (m_mode[v] != 0) m_nidx[v] <= (m_nidx[v] + 1) % LFSR_LEN;
                        else                m_sq[v]   <= 1 - m_sq[v];
                    end else begin
                        m_cnt[v] <= m_cnt[v] - 1;
                    end
                end
                if (wr_en && int'(wr_addr) / 2 == v) begin
                    if (int'(wr_addr) % 2 == 0) begin
                        m_per[v] <= int'(wr_data);
                        if (wr_data == 0) begin
                            m_cnt[v] <= 0;
                            m_sq[v]  <= 0;
                        end
                    end else begin
                        m_vol[v]  <= int'(wr_data) % (1 << VOL_W);
                        m_mode[v] <= (int'(wr_data) >> VOL_W) % 2;
                    end
                end
            end
            m_mix <= m_mix_next();
            m_pdm <= ((m_acc + m_mix) >= (1 << MIX_W)) ? 1 : 0;
            m_acc <= (m_acc + m_mix) % (1 << MIX_W);
        end
    end

    task automatic check_all();
        chk("voice_o", 32'(voice_o), 32'(m_voice_word()));
        chk("mix_o",   32'(mix_o),   32'(m_mix));
        chk("pdm_o",   32'(pdm_o),   32'(m_pdm));
        chk("tick_o",  32'(tick_o),  32'(m_tick));
    endtask

    // One clock: compare at the falling edge, then drive the next input set.
    task automatic cycle(input bit do_wr, input int v, input int sel, input int data);
        @(negedge clk);
        check_all();
        wr_en   = do_wr;
        wr_addr = AW'(v * 2 + sel);
        wr_data = PERIOD_W'(data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic count_pdm(input int n, output int ones);
        ones = 0;
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 0, 0, 0);
            ones += int'(pdm_o);
        end
    endtask

    initial begin
        int ones, peak, prev, last, tog, bad;
        int iv[3];
        bit do_w;

        for (int j = 0; j < 15; j++) seq[j] = 1'b1;
        for (int j = 15; j < SEQ_N; j++) seq[j] = seq[j-15] ^ seq[j-14];

        // Reset values and idle silence
        #23;
        chk("rst_voice", 32'(voice_o), 0);
        chk("rst_mix",   32'(mix_o),   0);
        chk("rst_pdm",   32'(pdm_o),   0);
        chk("rst_tick",  32'(tick_o),  0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1000);

        // Square tone on voice 0: half-period of 4 clocks
        do_reset();
        cycle(1'b1, 0, 1, 'h0F);
        cycle(1'b1, 0, 0, 3);
        prev = int'(voice_o[0]);
        last = -1;
        tog = 0;
        for (int c = 0; c < 40; c++) begin
            cycle(1'b0, 0, 0, 0);
            if (int'(voice_o[0]) != prev) begin
                if (last >= 0 && tog < 5) chk("sq_half", 32'(c - last), 4);
                last = c;
                tog++;
                prev = int'(voice_o[0]);
            end
        end
        chk("sq_toggles", 32'(tog >= 5), 1);

        // Constant mix of 15: exactly 15 carries per 128 clocks
        do_reset();
        cycle(1'b1, 0, 1, 'h0F);
        cycle(1'b1, 0, 0, 4095);
        idle(5);
        count_pdm(128, ones);
        chk("pdm_ones_15", 32'(ones), 15);

        // Full mix, all voices out of phase at period 5
        do_reset();
        for (int v = 0; v < VOICES; v++) cycle(1'b1, v, 1, 'h0F);
        for (int v = 0; v < VOICES; v++) cycle(1'b1, v, 0, 5);
        peak = 0;
        for (int c = 0; c < 200; c++) begin
            cycle(1'b0, 0, 0, 0);
            if (int'(mix_o) > peak) peak = int'(mix_o);
        end
        chk("mix_peak_p5", 32'(peak), 60);

        // Full mix held at 60: density 60/128
        do_reset();
        for (int v = 0; v < VOICES; v++) cycle(1'b1, v, 1, 'h0F);
        for (int v = 0; v < VOICES; v++) cycle(1'b1, v, 0, 4095);
        idle(5);
        chk("mix_full", 32'(mix_o), 60);
        count_pdm(128, ones);
        chk("pdm_ones_60", 32'(ones), 60);

        // Noise voice 1 at period 1: one LFSR step every 2 ticks
        do_reset();
        cycle(1'b1, 1, 1, 'h1F);
        cycle(1'b1, 1, 0, 1);
        cycle(1'b0, 0, 0, 0);
        chk("noise_seed", 32'(voice_o[1]), 32'(seq[14]));
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0, 0, 0, 0);
            chk($sformatf("noise_bit%0d", k), 32'(voice_o[1]), 32'(seq[14 + k]));
            cycle(1'b0, 0, 0, 0);
        end

        // Period change 10 -> 2 mid-count, then stop
        do_reset();
        cycle(1'b1, 2, 1, 'h0F);
        cycle(1'b1, 2, 0, 10);
        prev = int'(voice_o[2]);
        last = 0;
        tog = 0;
        iv = '{0, 0, 0};
        for (int c = 0; c < 80 && tog < 4; c++) begin
            do_w = (tog == 1) && (c - last == 4);
            cycle(do_w, 2, 0, 2);
            if (int'(voice_o[2]) != prev) begin
                if (tog >= 1 && tog <= 3) iv[tog-1] = c - last;
                last = c;
                tog++;
                prev = int'(voice_o[2]);
            end
        end
        chk("chg_toggles", 32'(tog), 4);
        chk("chg_half_old", 32'(iv[0]), 11);
        chk("chg_half_new1", 32'(iv[1]), 3);
        chk("chg_half_new2", 32'(iv[2]), 3);
        if (voice_o[2] == 1'b0) idle(3);
        cycle(1'b1, 2, 0, 0);
        cycle(1'b0, 0, 0, 0);
        chk("stop_next", 32'(voice_o[2]), 0);
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            cycle(1'b0, 0, 0, 0);
            bad += int'(voice_o[2]);
        end
        chk("stop_stays", 32'(bad), 0);

        // Asynchronous reset mid-note
        do_reset();
        for (int v = 0; v < VOICES; v++) cycle(1'b1, v, 1, 'h0F - v);
        for (int v = 0; v < VOICES; v++) cycle(1'b1, v, 0, 2 + v);
        idle(30);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_voice", 32'(voice_o), 0);
        chk("arst_mix",   32'(mix_o),   0);
        chk("arst_pdm",   32'(pdm_o),   0);
        chk("arst_tick",  32'(tick_o),  0);
        wr_en = 1'b0;
        @(negedge clk);
        #3 rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            cycle(1'b0, 0, 0, 0);
            if (voice_o != '0 || mix_o != '0 || pdm_o != 1'b0) bad++;
        end
        chk("arst_silent", 32'(bad), 0);

        // Random register traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(2, 0) == 0) begin
                if ($urandom_range(1, 0) == 0)
                    cycle(1'b1, $urandom_range(VOICES - 1, 0), 0,
                          ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(15, 1));
                else
                    cycle(1'b1, $urandom_range(VOICES - 1, 0), 1, $urandom_range(31, 0));
            end else begin
                cycle(1'b0, 0, 0, 0);
            end
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
